// File: rtl/ddr3_app_req_seq_pkg.sv
// Shared constants, state encoding and default widths for the DDR3 app request sequencer.
package ddr3_app_req_seq_pkg;

    localparam int DEF_ADDR_W     = 28;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_MAX_RD_OUT = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        IDLE,
        ISSUE
    } seq_state_t;

endpackage

// File: rtl/ddr3_rd_credit_cnt.sv
// Outstanding-read up/down counter; a return with nothing outstanding raises a sticky underflow flag.
module ddr3_rd_credit_cnt
    import ddr3_app_req_seq_pkg::*;
#(
    parameter int MAX_RD_OUT = DEF_MAX_RD_OUT,
    parameter int CNT_W      = $clog2(MAX_RD_OUT + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else begin
            if (dec && (cnt == '0))
                underflow <= 1'b1;
            if (inc && !dec)
                cnt <= cnt + 1'b1;
            else if (dec && !inc && (cnt != '0))
                cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/ddr3_app_req_seq.sv
// Turns client requests into DDR3 app-interface command/write-data handshakes and tracks reads in flight.
// Optional statistics counters are built when DDR3_SEQ_STATS_EN is defined.
//
// state | meaning
// IDLE  | no request held; req_ready may be high
// ISSUE | request registered; waiting for command and (for writes) data acceptance
module ddr3_app_req_seq
    import ddr3_app_req_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_RD_OUT = DEF_MAX_RD_OUT
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_wdata,
    input  logic [DATA_W/8-1:0]               req_wmask,
    output logic [ADDR_W-1:0]                 app_addr,
    output logic [2:0]                        app_cmd,
    output logic                              app_en,
    input  logic                              app_rdy,
    output logic [DATA_W-1:0]                 app_wdf_data,
    output logic [DATA_W/8-1:0]               app_wdf_mask,
    output logic                              app_wdf_wren,
    output logic                              app_wdf_end,
    input  logic                              app_wdf_rdy,
    input  logic                              app_rd_data_valid,
    input  logic                              init_calib_complete,
    output logic [$clog2(MAX_RD_OUT+1)-1:0]   rd_outstanding,
    output logic                              rd_underflow
`ifdef DDR3_SEQ_STATS_EN
    ,
    output logic [31:0]                       stat_wr_cnt,
    output logic [31:0]                       stat_rd_cnt,
    output logic [31:0]                       stat_stall_cnt
`endif
);

    localparam int              CNT_W   = $clog2(MAX_RD_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUT);

    seq_state_t state;
    logic       write_q;
    logic       cmd_done;
    logic       data_done;
    logic       cmd_done_nxt;
    logic       data_done_nxt;
    logic       cmd_acc;
    logic       data_acc;
    logic       rd_inc;

    assign cmd_acc       = app_en & app_rdy;
    assign data_acc      = app_wdf_wren & app_wdf_rdy;
    assign cmd_done_nxt  = cmd_done | cmd_acc;
    assign data_done_nxt = data_done | data_acc;
    assign rd_inc        = cmd_acc & ~write_q;
    assign app_wdf_end   = app_wdf_wren;

    // Gated by RST_N so nothing looks acceptable while reset is held.
    assign req_ready = RST_N && (state == IDLE) && init_calib_complete
                       && (rd_outstanding < MAX_CNT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            write_q      <= 1'b0;
            cmd_done     <= 1'b0;
            data_done    <= 1'b0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q      <= req_write;
                        app_addr     <= req_addr;
                        app_cmd      <= req_write ? CMD_WRITE : CMD_READ;
                        app_wdf_data <= req_wdata;
                        app_wdf_mask <= req_wmask;
                        cmd_done     <= 1'b0;
                        data_done    <= ~req_write;
                        app_en       <= 1'b1;
                        app_wdf_wren <= req_write;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    cmd_done  <= cmd_done_nxt;
                    data_done <= data_done_nxt;
                    if (cmd_done_nxt && data_done_nxt) begin
                        app_en       <= 1'b0;
                        app_wdf_wren <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        app_en       <= ~cmd_done_nxt;
                        app_wdf_wren <= write_q & ~data_done_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ddr3_rd_credit_cnt #(
        .MAX_RD_OUT (MAX_RD_OUT),
        .CNT_W      (CNT_W)
    ) u_rd_credit (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .inc        (rd_inc),
        .dec        (app_rd_data_valid),
        .cnt        (rd_outstanding),
        .underflow  (rd_underflow)
    );

`ifdef DDR3_SEQ_STATS_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stat_wr_cnt    <= '0;
            stat_rd_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (data_acc)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (rd_inc)
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if ((state == ISSUE) && ((app_en && !app_rdy) || (app_wdf_wren && !app_wdf_rdy)))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_app_req_seq.sv
// Bench for ddr3_app_req_seq: transaction-level reference model, directed scenarios, random traffic.
module tb_ddr3_app_req_seq;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 256;
    localparam int MAX_RD = 16;

    logic                 CLK;
    logic                 RST_N;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [ADDR_W-1:0]    req_addr;
    logic [DATA_W-1:0]    req_wdata;
    logic [DATA_W/8-1:0]  req_wmask;
    logic [ADDR_W-1:0]    app_addr;
    logic [2:0]           app_cmd;
    logic                 app_en;
    logic                 app_rdy;
    logic [DATA_W-1:0]    app_wdf_data;
    logic [DATA_W/8-1:0]  app_wdf_mask;
    logic                 app_wdf_wren;
    logic                 app_wdf_end;
    logic                 app_wdf_rdy;
    logic                 app_rd_data_valid;
    logic                 init_calib_complete;
    logic [4:0]           rd_outstanding;
    logic                 rd_underflow;
`ifdef DDR3_SEQ_STATS_EN
    logic [31:0]          stat_wr_cnt;
    logic [31:0]          stat_rd_cnt;
    logic [31:0]          stat_stall_cnt;
`endif

    ddr3_app_req_seq #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_RD_OUT (MAX_RD)
    ) dut (
        .CLK                 (CLK),
        .RST_N               (RST_N),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .req_wmask           (req_wmask),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data_valid   (app_rd_data_valid),
        .init_calib_complete (init_calib_complete),
        .rd_outstanding      (rd_outstanding),
        .rd_underflow        (rd_underflow)
`ifdef DDR3_SEQ_STATS_EN
        ,
        .stat_wr_cnt         (stat_wr_cnt),
        .stat_rd_cnt         (stat_rd_cnt),
        .stat_stall_cnt      (stat_stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model: one held request with "command pending" / "data pending" flags.
    bit                  m_busy;
    bit                  m_write;
    bit                  m_cmd_pend;
    bit                  m_dat_pend;
    logic [ADDR_W-1:0]   m_addr;
    logic [2:0]          m_cmd;
    logic [DATA_W-1:0]   m_data;
    logic [DATA_W/8-1:0] m_mask;
    int                  m_cnt;
    bit                  m_uf;
    int                  accepts;
    int                  en_seen;
    int                  wren_seen;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_write = 0; m_cmd_pend = 0; m_dat_pend = 0;
        m_addr = '0; m_cmd = '0; m_data = '0; m_mask = '0;
        m_cnt = 0; m_uf = 0;
    endtask

    // Called just after a negedge with inputs set; compares, advances the model, waits one cycle.
    task automatic step();
        bit exp_ready, exp_en, exp_wren, acc, cmd_acc, dat_acc, inc, dec;
        #1;
        if (!RST_N) model_reset();
        exp_ready = RST_N && !m_busy && init_calib_complete && (m_cnt < MAX_RD);
        exp_en    = m_busy && m_cmd_pend;
        exp_wren  = m_busy && m_write && m_dat_pend;
        chk("req_ready", req_ready, exp_ready);
        chk("app_en", app_en, exp_en);
        chk("app_wdf_wren", app_wdf_wren, exp_wren);
        chk("app_wdf_end", app_wdf_end, exp_wren);
        chk("app_cmd", app_cmd, m_cmd);
        chk("app_addr", app_addr, m_addr);
        chk("app_wdf_data", app_wdf_data, m_data);
        chk("app_wdf_mask", app_wdf_mask, m_mask);
        chk("rd_outstanding", rd_outstanding, m_cnt);
        chk("rd_underflow", rd_underflow, m_uf);
        if (app_en) en_seen++;
        if (app_wdf_wren) wren_seen++;
        if (RST_N) begin
            acc     = req_valid && exp_ready;
            cmd_acc = exp_en && app_rdy;
            dat_acc = exp_wren && app_wdf_rdy;
            inc     = cmd_acc && !m_write;
            dec     = app_rd_data_valid;
            if (dec && m_cnt == 0) m_uf = 1;
            if (inc && !dec) m_cnt++;
            else if (dec && !inc && m_cnt > 0) m_cnt--;
            if (m_busy) begin
                if (cmd_acc) m_cmd_pend = 0;
                if (dat_acc) m_dat_pend = 0;
                if (!m_cmd_pend && !m_dat_pend) m_busy = 0;
            end
            if (acc) begin
                m_busy     = 1;
                m_write    = req_write;
                m_cmd_pend = 1;
                m_dat_pend = req_write;
                m_addr     = req_addr;
                m_cmd      = req_write ? 3'b000 : 3'b001;
                m_data     = req_wdata;
                m_mask     = req_wmask;
                accepts++;
            end
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wmask = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0; init_calib_complete = 1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST_N = 0;
        step();
        step();
        RST_N = 1;
    endtask

    task automatic send(input bit wr, input logic [ADDR_W-1:0] a);
        req_valid = 1; req_write = wr; req_addr = a;
        req_wdata = {8{$urandom()}}; req_wmask = $urandom();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle_inputs();
        RST_N = 0;
        @(negedge CLK);
        step();
        chk("rst_app_en", app_en, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_app_cmd", app_cmd, 0);
        step();
        RST_N = 1;
        #1;
        chk("post_rst_ready", req_ready, 1);

        // Write with both sides ready: one-cycle strobes, back to IDLE two cycles after accept.
        req_valid = 1; req_write = 1; req_addr = 28'h0000100;
        req_wdata = {32{8'hA5}}; req_wmask = '0;
        step();
        req_valid = 0;
        en_seen = 0; wren_seen = 0;
        #1;
        chk("w1_app_en", app_en, 1);
        chk("w1_wren", app_wdf_wren, 1);
        chk("w1_cmd", app_cmd, 3'b000);
        chk("w1_addr", app_addr, 28'h0000100);
        chk("w1_data", app_wdf_data, {32{8'hA5}});
        step();
        chk("w1_idle_ready", req_ready, 1);
        step(); step();
        chk("w1_en_cycles", en_seen, 1);
        chk("w1_wren_cycles", wren_seen, 1);

        // Write with app_rdy low for three ISSUE cycles.
        do_reset();
        send(1, 28'h0ABCDEF);
        step();
        req_valid = 0; app_rdy = 0; app_wdf_rdy = 1;
        en_seen = 0; wren_seen = 0;
        step(); step(); step();
        app_rdy = 1;
        step(); step(); step();
        chk("w2_en_cycles", en_seen, 4);
        chk("w2_wren_cycles", wren_seen, 1);

        // Sixteen reads fill the credit; one return frees one.
        do_reset();
        accepts = 0;
        for (int i = 0; i < 200 && accepts < MAX_RD; i++) begin
            send(0, ADDR_W'(i * 8));
            step();
        end
        chk("rd16_accepts", accepts, 16);
        step(); step(); step();
        chk("rd16_count", rd_outstanding, 16);
        chk("rd16_ready_low", req_ready, 0);
        req_valid = 0; app_rd_data_valid = 1;
        step();
        app_rd_data_valid = 0;
        #1;
        chk("rd15_count", rd_outstanding, 15);
        chk("rd15_ready_high", req_ready, 1);

        // Read command accept coincides with a returned beat at count 5.
        do_reset();
        accepts = 0;
        for (int i = 0; i < 50 && accepts < 5; i++) begin
            send(0, 28'h100 + ADDR_W'(i));
            step();
        end
        req_valid = 0;
        step(); step();
        chk("rd5_count", rd_outstanding, 5);
        send(0, 28'h200);
        step();
        req_valid = 0; app_rd_data_valid = 1;
        step();
        app_rd_data_valid = 0;
        #1;
        chk("rd5_same_cycle", rd_outstanding, 5);

        // Return with nothing outstanding.
        do_reset();
        app_rd_data_valid = 1;
        step();
        app_rd_data_valid = 0;
        #1;
        chk("uf_count", rd_outstanding, 0);
        chk("uf_flag", rd_underflow, 1);
        step(); step(); step();
        chk("uf_sticky", rd_underflow, 1);
        do_reset();
        #1;
        chk("uf_cleared", rd_underflow, 0);

        // Reset in the middle of ISSUE.
        step();
        app_rdy = 0; app_wdf_rdy = 0;
        send(1, 28'h0FFFFFF);
        step();
        req_valid = 0;
        step();
        chk("mid_issue_en", app_en, 1);
        RST_N = 0;
        #1;
        chk("rst_mid_en", app_en, 0);
        chk("rst_mid_wren", app_wdf_wren, 0);
        chk("rst_mid_end", app_wdf_end, 0);
        chk("rst_mid_addr", app_addr, 0);
        chk("rst_mid_data", app_wdf_data, 0);
        chk("rst_mid_mask", app_wdf_mask, 0);
        chk("rst_mid_ready", req_ready, 0);
        step(); step();
        RST_N = 1; app_rdy = 1; app_wdf_rdy = 1;
        req_valid = 1; req_write = 1; req_addr = 28'h0000055;
        req_wdata = {8{32'h1234_5678}}; req_wmask = 32'h0000_000F;
        step();
        req_valid = 0;
        #1;
        chk("post_rst_en", app_en, 1);
        chk("post_rst_wren", app_wdf_wren, 1);
        chk("post_rst_addr", app_addr, 28'h0000055);
        chk("post_rst_mask", app_wdf_mask, 32'h0000_000F);
        step();
        chk("post_rst_idle", req_ready, 1);

        // Random traffic with occasional calibration drops and resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            req_valid           = ($urandom_range(0, 2) != 0);
            req_write           = $urandom_range(0, 1);
            req_addr            = ADDR_W'($urandom());
            req_wdata           = {8{$urandom()}};
            req_wmask           = $urandom();
            app_rdy             = ($urandom_range(0, 3) != 0);
            app_wdf_rdy         = ($urandom_range(0, 3) != 0);
            init_calib_complete = ($urandom_range(0, 19) != 0);
            app_rd_data_valid   = (m_cnt > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr3_app_req_seq.md
DDR3_APP_REQ_SEQ -- requirements
Module: ddr3_app_req_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 28, memory-controller app address width.
REQ-002 The block SHALL have parameter DATA_W, default 256, app data width; mask width is DATA_W/8.
REQ-003 The block SHALL have parameter MAX_RD_OUT, default 16, maximum reads issued but not yet returned.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with these ports in order:
- CLK  in  1  sole clock; the controller user-interface clock domain.
- RST_N  in  1  asynchronous reset, active-low.
- req_valid  in  1  client request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_wmask  in  DATA_W/8  byte mask; 1 = byte not written.
- app_addr  out  ADDR_W  controller address.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_en  out  1  command strobe.
- app_rdy  in  1  controller accepts the command.
- app_wdf_data  out  DATA_W  write data.
- app_wdf_mask  out  DATA_W/8  write mask.
- app_wdf_wren  out  1  write-data strobe.
- app_wdf_end  out  1  last beat; always equals app_wdf_wren.
- app_wdf_rdy  in  1  controller accepts the write data.
- app_rd_data_valid  in  1  one read beat is returned.
- init_calib_complete  in  1  controller is calibrated.
- rd_outstanding  out  clog2(MAX_RD_OUT+1)  count of reads in flight.
- rd_underflow  out  1  sticky error flag.

Function
REQ-005 The state machine SHALL have two states: IDLE and ISSUE.
REQ-006 req_ready SHALL be 1 only when all hold: state is IDLE, init_calib_complete = 1, rd_outstanding < MAX_RD_OUT. It SHALL NOT depend on req_valid.
REQ-007 On accept, the block SHALL register write/addr/wdata/wmask, clear the flags cmd_done and data_done, and enter ISSUE on the next cycle.
- For a read, data_done SHALL be set to 1 at accept.
REQ-008 In ISSUE, outputs SHALL be driven as follows:
- app_en = !cmd_done.
- app_wdf_wren = app_wdf_end = write & !data_done.
- app_addr, app_cmd, app_wdf_data, app_wdf_mask come from the registered request.
REQ-009 cmd_done SHALL set on app_en & app_rdy. data_done SHALL set on app_wdf_wren & app_wdf_rdy. The two acceptances are independent and may occur in either order or in the same cycle.
REQ-010 ISSUE SHALL return to IDLE in the cycle after both flags are set; this includes both being satisfied in the same cycle.
- Minimum latency: accept in cycle N, app_en high in N+1, back in IDLE in N+2.
- Throughput: one request per 2 cycles at best.
REQ-011 In IDLE, app_en and app_wdf_wren SHALL be 0, and all app_* data and address outputs SHALL hold their last values.
REQ-012 rd_outstanding SHALL update as follows:
- +1 on a read command accept (app_en & app_rdy & !write).
- -1 on app_rd_data_valid.
- Unchanged when both occur in the same cycle.
REQ-013 If app_rd_data_valid arrives while rd_outstanding = 0, the counter SHALL stay at 0 and rd_underflow SHALL set and remain set until reset.
REQ-014 If init_calib_complete falls while in ISSUE, the block SHALL finish the current request normally and then accept nothing new.

Reset
REQ-015 Asserting RST_N low SHALL immediately force these values, regardless of any request in progress; the partial request is dropped:
- state = IDLE.
- app_en = 0, app_wdf_wren = 0, app_wdf_end = 0.
- app_addr, app_cmd, app_wdf_data, app_wdf_mask = 0.
- rd_outstanding = 0, rd_underflow = 0, req_ready = 0, all internal flags = 0.
REQ-016 Reset deassertion is synchronized by the environment; the block SHALL operate from the first clock edge after RST_N rises.

Configuration
REQ-017 With DDR3_SEQ_STATS_EN defined, the block SHALL add three 32-bit outputs, each wrapping at 2^32 and reset to 0:
- stat_wr_cnt: counts data_done write completions.
- stat_rd_cnt: counts read command accepts.
- stat_stall_cnt: counts ISSUE cycles in which app_en & !app_rdy, or app_wdf_wren & !app_wdf_rdy.
REQ-018 Without DDR3_SEQ_STATS_EN, those ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Structure
REQ-019 A shared package SHALL hold:
- The command constants CMD_WRITE = 3'b000 and CMD_READ = 3'b001.
- The state enum {IDLE, ISSUE}.
- Default widths.
REQ-020 The outstanding-read up/down counter with underflow detection SHALL be one sub-module, ddr3_rd_credit_cnt. Everything else stays flat.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write, addr 0x0000100, data all-0xA5, mask 0, with app_rdy = app_wdf_rdy = 1 → app_en and app_wdf_wren are both high for exactly 1 cycle, app_cmd = 000, back to IDLE 2 cycles after accept.
- Write with app_rdy held low 3 cycles and app_wdf_rdy = 1 → wren is high for 1 cycle, app_en is high for 4 cycles, no duplicate data beat.
- 16 back-to-back reads with no app_rd_data_valid → rd_outstanding = 16 and req_ready stays low. One app_rd_data_valid → 15 and req_ready returns high.
- Read command accept in the same cycle as app_rd_data_valid with count 5 → count stays 5.
- app_rd_data_valid while the count is 0 → count stays 0 and rd_underflow = 1 until reset.
- RST_N low in the middle of ISSUE → all outputs are zero in that cycle, and the next request after release is issued cleanly.
